reservation_station_param: RTL and testbench

- Parametrised reservation station for the out-of-order RISC-V core.
- Sits between the decoder/issue stage and the ALU.
- Buffers up to DEPTH ALU instructions and snoops two CDB channels (ALU result, LSB result) for operand wakeup.
- Dispatches one ready instruction per cycle to the ALU over a valid/ready handshake; flushes on branch mispredict.

---
 rtl/reservation_station_param.sv | 204 ++++++++++++++++++++
 tb/tb_reservation_station_param.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station_param.sv
`default_nettype none
// ============================================================================
// Module   : reservation_station_param
// Purpose  : ALU reservation station with dual-CDB operand wakeup and a
//            valid/ready dispatch register toward the ALU.
// Revision : 1.0 - initial release
// ============================================================================
module reservation_station_param #(
  parameter int DEPTH    = 16,
  parameter int ROB_ADDR = 4,
  parameter int OP_W     = 6,
  parameter int XLEN     = 32,
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                rdy_in,
  input  logic                flush_in,
  input  logic                issue_valid_in,
  input  logic [OP_W-1:0]     issue_op_in,
  input  logic [XLEN-1:0]     issue_vj_in,
  input  logic [XLEN-1:0]     issue_vk_in,
  input  logic                issue_qj_valid_in,
  input  logic [ROB_ADDR-1:0] issue_qj_in,
  input  logic                issue_qk_valid_in,
  input  logic [ROB_ADDR-1:0] issue_qk_in,
  input  logic [ROB_ADDR-1:0] issue_robidx_in,
  output logic                rs_full_out,
  output logic [CNT_W-1:0]    rs_count_out,
  input  logic                cdb0_valid_in,
  input  logic [ROB_ADDR-1:0] cdb0_robidx_in,
  input  logic [XLEN-1:0]     cdb0_value_in,
  input  logic                cdb1_valid_in,
  input  logic [ROB_ADDR-1:0] cdb1_robidx_in,
  input  logic [XLEN-1:0]     cdb1_value_in,
  output logic                alu_valid_out,
  input  logic                alu_ready_in,
  output logic [OP_W-1:0]     alu_op_out,
  output logic [XLEN-1:0]     alu_vj_out,
  output logic [XLEN-1:0]     alu_vk_out,
  output logic [ROB_ADDR-1:0] alu_robidx_out
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]    r_busy;
  logic [DEPTH-1:0]    r_qjv;
  logic [DEPTH-1:0]    r_qkv;
  logic [OP_W-1:0]     r_op  [DEPTH];
  logic [XLEN-1:0]     r_vj  [DEPTH];
  logic [XLEN-1:0]     r_vk  [DEPTH];
  logic [ROB_ADDR-1:0] r_qj  [DEPTH];
  logic [ROB_ADDR-1:0] r_qk  [DEPTH];
  logic [ROB_ADDR-1:0] r_rob [DEPTH];
  logic [CNT_W-1:0]    r_count;

  logic                r_alu_valid;
  logic [OP_W-1:0]     r_alu_op;
  logic [XLEN-1:0]     r_alu_vj;
  logic [XLEN-1:0]     r_alu_vk;
  logic [ROB_ADDR-1:0] r_alu_rob;

  logic [DEPTH-1:0]    w_ready;
  logic [IDX_W-1:0]    w_free_idx;
  logic [IDX_W-1:0]    w_sel_idx;
  logic                w_any_ready;
  logic                w_load;
  logic                w_issue;
  logic                w_dispatch;
  logic [XLEN-1:0]     w_iss_vj;
  logic [XLEN-1:0]     w_iss_vk;
  logic                w_iss_qjv;
  logic                w_iss_qkv;

  assign w_ready      = r_busy & ~r_qjv & ~r_qkv;
  assign rs_count_out = r_count;
  assign rs_full_out  = (r_count == CNT_W'(DEPTH));
  assign w_load       = !r_alu_valid || alu_ready_in;
  assign w_issue      = issue_valid_in && !rs_full_out;
  assign w_dispatch   = w_load && w_any_ready;

  // Scanning downward leaves the lowest matching index in each selector.
  always_comb begin
    w_free_idx  = '0;
    w_sel_idx   = '0;
    w_any_ready = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_busy[i]) w_free_idx = IDX_W'(i);
      if (w_ready[i]) begin
        w_sel_idx   = IDX_W'(i);
        w_any_ready = 1'b1;
      end
    end
  end

  // Same-cycle CDB bypass for the instruction being issued; cdb0 wins.
  always_comb begin
    w_iss_vj  = issue_vj_in;
    w_iss_qjv = issue_qj_valid_in;
    w_iss_vk  = issue_vk_in;
    w_iss_qkv = issue_qk_valid_in;
    if (issue_qj_valid_in) begin
      if (cdb0_valid_in && (cdb0_robidx_in == issue_qj_in)) begin
        w_iss_vj  = cdb0_value_in;
        w_iss_qjv = 1'b0;
      end else if (cdb1_valid_in && (cdb1_robidx_in == issue_qj_in)) begin
        w_iss_vj  = cdb1_value_in;
        w_iss_qjv = 1'b0;
      end
    end
    if (issue_qk_valid_in) begin
      if (cdb0_valid_in && (cdb0_robidx_in == issue_qk_in)) begin
        w_iss_vk  = cdb0_value_in;
        w_iss_qkv = 1'b0;
      end else if (cdb1_valid_in && (cdb1_robidx_in == issue_qk_in)) begin
        w_iss_vk  = cdb1_value_in;
        w_iss_qkv = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_busy      <= '0;
      r_qjv       <= '0;
      r_qkv       <= '0;
      r_count     <= '0;
      r_alu_valid <= 1'b0;
      r_alu_op    <= '0;
      r_alu_vj    <= '0;
      r_alu_vk    <= '0;
      r_alu_rob   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_op[i]  <= '0;
        r_vj[i]  <= '0;
        r_vk[i]  <= '0;
        r_qj[i]  <= '0;
        r_qk[i]  <= '0;
        r_rob[i] <= '0;
      end
    end else if (rdy_in) begin
      if (flush_in) begin
        r_busy      <= '0;
        r_count     <= '0;
        r_alu_valid <= 1'b0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_busy[i] && r_qjv[i]) begin
            if (cdb0_valid_in && (cdb0_robidx_in == r_qj[i])) begin
              r_vj[i]  <= cdb0_value_in;
              r_qjv[i] <= 1'b0;
            end else if (cdb1_valid_in && (cdb1_robidx_in == r_qj[i])) begin
              r_vj[i]  <= cdb1_value_in;
              r_qjv[i] <= 1'b0;
            end
          end
          if (r_busy[i] && r_qkv[i]) begin
            if (cdb0_valid_in && (cdb0_robidx_in == r_qk[i])) begin
              r_vk[i]  <= cdb0_value_in;
              r_qkv[i] <= 1'b0;
            end else if (cdb1_valid_in && (cdb1_robidx_in == r_qk[i])) begin
              r_vk[i]  <= cdb1_value_in;
              r_qkv[i] <= 1'b0;
            end
          end
        end

        if (w_dispatch) begin
          r_busy[w_sel_idx] <= 1'b0;
          r_alu_valid       <= 1'b1;
          r_alu_op          <= r_op[w_sel_idx];
          r_alu_vj          <= r_vj[w_sel_idx];
          r_alu_vk          <= r_vk[w_sel_idx];
          r_alu_rob         <= r_rob[w_sel_idx];
        end else if (w_load) begin
          r_alu_valid <= 1'b0;
        end

        // The free slot is never busy, so it cannot collide with the dispatch slot.
        if (w_issue) begin
          r_busy[w_free_idx] <= 1'b1;
          r_op[w_free_idx]   <= issue_op_in;
          r_vj[w_free_idx]   <= w_iss_vj;
          r_vk[w_free_idx]   <= w_iss_vk;
          r_qjv[w_free_idx]  <= w_iss_qjv;
          r_qkv[w_free_idx]  <= w_iss_qkv;
          r_qj[w_free_idx]   <= issue_qj_in;
          r_qk[w_free_idx]   <= issue_qk_in;
          r_rob[w_free_idx]  <= issue_robidx_in;
        end

        r_count <= r_count + CNT_W'(w_issue) - CNT_W'(w_dispatch);
      end
    end
  end

  assign alu_valid_out  = r_alu_valid;
  assign alu_op_out     = r_alu_op;
  assign alu_vj_out     = r_alu_vj;
  assign alu_vk_out     = r_alu_vk;
  assign alu_robidx_out = r_alu_rob;

endmodule
`default_nettype wire

// File: tb/tb_reservation_station_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_reservation_station_param
// Purpose  : Directed scoreboard bench for reservation_station_param.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reservation_station_param;

  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk_in = 1'b0;
  logic             rst_n_in, rdy_in, flush_in;
  logic             issue_valid_in, issue_qj_valid_in, issue_qk_valid_in;
  logic [5:0]       issue_op_in;
  logic [31:0]      issue_vj_in, issue_vk_in;
  logic [3:0]       issue_qj_in, issue_qk_in, issue_robidx_in;
  logic             rs_full_out;
  logic [CNT_W-1:0] rs_count_out;
  logic             cdb0_valid_in, cdb1_valid_in;
  logic [3:0]       cdb0_robidx_in, cdb1_robidx_in;
  logic [31:0]      cdb0_value_in, cdb1_value_in;
  logic             alu_valid_out, alu_ready_in;
  logic [5:0]       alu_op_out;
  logic [31:0]      alu_vj_out, alu_vk_out;
  logic [3:0]       alu_robidx_out;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] vj;
    logic [31:0] vk;
    logic [3:0]  rob;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  reservation_station_param #(.DEPTH(DEPTH), .ROB_ADDR(4), .OP_W(6), .XLEN(32)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .issue_valid_in(issue_valid_in), .issue_op_in(issue_op_in),
    .issue_vj_in(issue_vj_in), .issue_vk_in(issue_vk_in),
    .issue_qj_valid_in(issue_qj_valid_in), .issue_qj_in(issue_qj_in),
    .issue_qk_valid_in(issue_qk_valid_in), .issue_qk_in(issue_qk_in),
    .issue_robidx_in(issue_robidx_in), .rs_full_out(rs_full_out),
    .rs_count_out(rs_count_out),
    .cdb0_valid_in(cdb0_valid_in), .cdb0_robidx_in(cdb0_robidx_in), .cdb0_value_in(cdb0_value_in),
    .cdb1_valid_in(cdb1_valid_in), .cdb1_robidx_in(cdb1_robidx_in), .cdb1_value_in(cdb1_value_in),
    .alu_valid_out(alu_valid_out), .alu_ready_in(alu_ready_in), .alu_op_out(alu_op_out),
    .alu_vj_out(alu_vj_out), .alu_vk_out(alu_vk_out), .alu_robidx_out(alu_robidx_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive_issue(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                             input logic qjv, input logic [3:0] qj,
                             input logic qkv, input logic [3:0] qk, input logic [3:0] rob);
    issue_valid_in    = 1'b1;
    issue_op_in       = op;
    issue_vj_in       = vj;
    issue_vk_in       = vk;
    issue_qj_valid_in = qjv;
    issue_qj_in       = qj;
    issue_qk_valid_in = qkv;
    issue_qk_in       = qk;
    issue_robidx_in   = rob;
  endtask

  task automatic cdb_idle();
    cdb0_valid_in = 1'b0;
    cdb1_valid_in = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 60 && q.size() != 0; n++) tick();
    chk(name, 32'(q.size()), 32'd0);
  endtask

  // Monitor: every presented ALU output is compared to the head of the queue;
  // it is popped only when the handshake completes at the coming edge.
  always @(negedge clk_in) begin
    if (rst_n_in && alu_valid_out) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_dispatch: got op=0x%0h rob=%0d expected no dispatch",
                 alu_op_out, alu_robidx_out);
      end else begin
        if ({alu_op_out, alu_vj_out, alu_vk_out, alu_robidx_out} !== q[0]) begin
          errors++;
          $display("FAIL dispatch: got op=0x%0h vj=0x%0h vk=0x%0h rob=%0d expected op=0x%0h vj=0x%0h vk=0x%0h rob=%0d",
                   alu_op_out, alu_vj_out, alu_vk_out, alu_robidx_out,
                   q[0].op, q[0].vj, q[0].vk, q[0].rob);
        end
        if (alu_ready_in) void'(q.pop_front());
      end
    end
  end

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; alu_ready_in = 1'b1;
    issue_valid_in = 1'b0; issue_op_in = '0; issue_vj_in = '0; issue_vk_in = '0;
    issue_qj_valid_in = 1'b0; issue_qj_in = '0; issue_qk_valid_in = 1'b0;
    issue_qk_in = '0; issue_robidx_in = '0;
    cdb0_valid_in = 1'b0; cdb0_robidx_in = '0; cdb0_value_in = '0;
    cdb1_valid_in = 1'b0; cdb1_robidx_in = '0; cdb1_value_in = '0;

    // Reset state
    tick(); tick();
    chk("rst_valid", 32'(alu_valid_out), 32'd0);
    chk("rst_count", 32'(rs_count_out), 32'd0);
    chk("rst_full", 32'(rs_full_out), 32'd0);
    chk("rst_outs", {alu_op_out, alu_robidx_out, 22'd0} | alu_vj_out | alu_vk_out, 32'd0);
    rst_n_in = 1'b1;
    tick();

    // Ready-at-issue instruction: valid one edge after issue
    q.push_back('{op: 6'h01, vj: 32'd5, vk: 32'd7, rob: 4'd4});
    drive_issue(6'h01, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd4);
    tick();
    issue_valid_in = 1'b0;
    chk("t1_count_after_issue", 32'(rs_count_out), 32'd1);
    chk("t1_valid_after_issue", 32'(alu_valid_out), 32'd0);
    tick();
    chk("t1_valid_latency", 32'(alu_valid_out), 32'd1);
    chk("t1_count_back", 32'(rs_count_out), 32'd0);
    tick();
    chk("t1_valid_drop", 32'(alu_valid_out), 32'd0);

    // Wakeup via cdb1; a broadcast while rdy_in is low must be ignored
    q.push_back('{op: 6'h02, vj: 32'hDEADBEEF, vk: 32'd1, rob: 4'd5});
    drive_issue(6'h02, 32'h55, 32'd1, 1'b1, 4'd3, 1'b0, 4'd0, 4'd5);
    tick();
    issue_valid_in = 1'b0;
    rdy_in = 1'b0;
    cdb1_valid_in = 1'b1; cdb1_robidx_in = 4'd3; cdb1_value_in = 32'h1234;
    tick();
    rdy_in = 1'b1;
    cdb_idle();
    tick();
    chk("t2_frozen_no_wake", 32'(alu_valid_out), 32'd0);
    cdb1_valid_in = 1'b1; cdb1_robidx_in = 4'd3; cdb1_value_in = 32'hDEADBEEF;
    tick();
    cdb_idle();
    chk("t2_wake_not_same_edge", 32'(alu_valid_out), 32'd0);
    tick();
    chk("t2_dispatch_after_wake", 32'(alu_valid_out), 32'd1);
    drain("t2_drain");

    // Issue bypass on k with both CDBs matching: cdb0 wins
    q.push_back('{op: 6'h03, vj: 32'd9, vk: 32'h10, rob: 4'd6});
    drive_issue(6'h03, 32'd9, 32'hBAD, 1'b0, 4'd0, 1'b1, 4'd2, 4'd6);
    cdb0_valid_in = 1'b1; cdb0_robidx_in = 4'd2; cdb0_value_in = 32'h10;
    cdb1_valid_in = 1'b1; cdb1_robidx_in = 4'd2; cdb1_value_in = 32'h20;
    tick();
    issue_valid_in = 1'b0;
    cdb_idle();
    tick();
    chk("t3_bypass_dispatch", 32'(alu_valid_out), 32'd1);
    drain("t3_drain");

    // Fill to full, drop the 17th, stall then drain in index order
    alu_ready_in = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive_issue(6'(i), 32'(100 + i), 32'h0, 1'b0, 4'd0, 1'b1, 4'd9, 4'(i));
      q.push_back('{op: 6'(i), vj: 32'(100 + i), vk: 32'hAAAA0000, rob: 4'(i)});
      tick();
    end
    issue_valid_in = 1'b0;
    chk("t4_count_full", 32'(rs_count_out), 32'd16);
    chk("t4_full_flag", 32'(rs_full_out), 32'd1);
    drive_issue(6'h3F, 32'hFFFF, 32'hFFFF, 1'b0, 4'd0, 1'b0, 4'd0, 4'd15);
    tick();
    issue_valid_in = 1'b0;
    chk("t4_17th_dropped", 32'(rs_count_out), 32'd16);
    cdb0_valid_in = 1'b1; cdb0_robidx_in = 4'd9; cdb0_value_in = 32'hAAAA0000;
    tick();
    cdb_idle();
    tick();
    chk("t4_stall_valid", 32'(alu_valid_out), 32'd1);
    chk("t4_count_15", 32'(rs_count_out), 32'd15);
    repeat (5) tick();
    alu_ready_in = 1'b1;
    drain("t4_drain");
    chk("t4_count_zero", 32'(rs_count_out), 32'd0);

    // Slots 2 and 5 wake together; slot 2 goes first. Then flush with issue.
    for (int i = 0; i < 6; i++) begin
      logic [3:0] tag;
      tag = (i == 2) ? 4'd1 : ((i == 5) ? 4'd2 : 4'd7);
      drive_issue(6'(8'h20 + i), 32'h0, 32'(i), 1'b1, tag, 1'b0, 4'd0, 4'(i));
      tick();
    end
    issue_valid_in = 1'b0;
    q.push_back('{op: 6'h22, vj: 32'h111, vk: 32'd2, rob: 4'd2});
    q.push_back('{op: 6'h25, vj: 32'h222, vk: 32'd5, rob: 4'd5});
    cdb0_valid_in = 1'b1; cdb0_robidx_in = 4'd1; cdb0_value_in = 32'h111;
    cdb1_valid_in = 1'b1; cdb1_robidx_in = 4'd2; cdb1_value_in = 32'h222;
    tick();
    cdb_idle();
    tick(); tick(); tick();
    chk("t5_count_4", 32'(rs_count_out), 32'd4);
    chk("t5_queue_done", 32'(q.size()), 32'd0);
    flush_in = 1'b1;
    drive_issue(6'h30, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd8);
    tick();
    flush_in = 1'b0;
    issue_valid_in = 1'b0;
    chk("t5_flush_count", 32'(rs_count_out), 32'd0);
    chk("t5_flush_valid", 32'(alu_valid_out), 32'd0);
    cdb0_valid_in = 1'b1; cdb0_robidx_in = 4'd7; cdb0_value_in = 32'h77;
    tick();
    cdb_idle();
    tick();
    chk("t5_flushed_stay_empty", 32'(alu_valid_out), 32'd0);
    chk("t5_flushed_count", 32'(rs_count_out), 32'd0);

    // Asynchronous reset while stalled
    alu_ready_in = 1'b0;
    q.push_back('{op: 6'h11, vj: 32'd3, vk: 32'd4, rob: 4'd10});
    drive_issue(6'h11, 32'd3, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0, 4'd10);
    tick();
    drive_issue(6'h12, 32'd0, 32'd0, 1'b1, 4'd12, 1'b0, 4'd0, 4'd11);
    tick();
    issue_valid_in = 1'b0;
    chk("t6_stalled_valid", 32'(alu_valid_out), 32'd1);
    chk("t6_count_1", 32'(rs_count_out), 32'd1);
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("t6_async_valid", 32'(alu_valid_out), 32'd0);
    chk("t6_async_count", 32'(rs_count_out), 32'd0);
    void'(q.pop_front());
    tick();
    rst_n_in = 1'b1;
    alu_ready_in = 1'b1;
    tick(); tick();
    chk("t6_post_reset_idle", 32'(alu_valid_out), 32'd0);
    chk("final_queue_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
